// File: rtl/uart_wb_master.sv
// uart_wb_master: UART-driven Wishbone classic master for bring-up; define UART_WB_TIMEOUT_EN to abort unacknowledged cycles.
module uart_wb_master #(
  parameter logic [15:0] CLK_DIV = 16'd217,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        busy
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_WDATA, P_BUS, P_RESP} p_state_t;
  logic        rx_s1, rx_s2, rx_d;
  rx_state_t   rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_data;
  logic        rx_valid, rx_ferr;
  logic        tx_act, tx_end, tx_load;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_idx;
  logic [9:0]  tx_sh;
  p_state_t    st;
  logic        is_wr;
  logic [1:0]  bcnt;
  logic [31:0] resp;
  logic [2:0]  resp_left;
`ifdef UART_WB_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif
  assign tx_end  = tx_act && tx_idx == 4'd9 && tx_cnt == CLK_DIV - 16'd1;
  assign tx_load = st == P_RESP && resp_left != 3'd0 && (!tx_act || tx_end);
  // two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else {rx_s1, rx_s2, rx_d} <= {ser_rx, rx_s1, rx_s2};
  // RX: start bit re-checked at half a bit, then one sample per bit period
  always_ff @(posedge wb_clk_i) begin
    rx_valid <= 1'b0;
    rx_ferr  <= 1'b0;
    if (wb_rst_i) begin
      rx_st   <= R_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
    end else begin
      case (rx_st)
        R_IDLE:
          if (rx_d && !rx_s2) begin
            rx_st  <= R_START;
            rx_cnt <= 16'd1;
          end
        R_START:
          if (rx_cnt == CLK_DIV / 16'd2) begin
            rx_st  <= rx_s2 ? R_IDLE : R_DATA;
            rx_cnt <= 16'd1;
            rx_bit <= '0;
          end else rx_cnt <= rx_cnt + 16'd1;
        R_DATA:
          if (rx_cnt == CLK_DIV) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= 16'd1;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else rx_cnt <= rx_cnt + 16'd1;
        R_STOP:
          if (rx_cnt == CLK_DIV) begin
            rx_st    <= R_IDLE;
            rx_valid <= rx_s2;
            rx_ferr  <= !rx_s2;
            rx_data  <= rx_sh;
          end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_st <= R_IDLE;
      endcase
    end
  end
  // TX: reloads on the last stop-bit cycle so response frames run back-to-back
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      tx_act <= 1'b0;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '1;
      ser_tx <= 1'b1;
    end else if (tx_load) begin
      tx_sh  <= {1'b1, resp[31:24], 1'b0};
      ser_tx <= 1'b0;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_act <= 1'b1;
    end else if (tx_act) begin
      if (tx_cnt == CLK_DIV - 16'd1) begin
        tx_cnt <= '0;
        tx_act <= !tx_end;
        tx_idx <= tx_idx + 4'd1;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        ser_tx <= tx_end ? 1'b1 : tx_sh[1];
      end else tx_cnt <= tx_cnt + 16'd1;
    end
  // command parser and bus sequencer; all bus outputs registered
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      st        <= P_IDLE;
      is_wr     <= 1'b0;
      bcnt      <= '0;
      resp      <= '0;
      resp_left <= '0;
      busy      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
`ifdef UART_WB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (st)
        P_IDLE:
          if (rx_valid && (rx_data == 8'h01 || rx_data == 8'h02)) begin
            st    <= P_ADDR;
            is_wr <= rx_data[0];
            bcnt  <= '0;
            busy  <= 1'b1;
          end
        P_ADDR:
          if (rx_ferr) begin
            st   <= P_IDLE;
            busy <= 1'b0;
          end else if (rx_valid) begin
            wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
            bcnt      <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              st <= is_wr ? P_WDATA : P_BUS;
              if (!is_wr) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_sel_o <= 4'hF;
                wbm_we_o  <= 1'b0;
`ifdef UART_WB_TIMEOUT_EN
                to_cnt    <= '0;
`endif
              end
            end
          end
        P_WDATA:
          if (rx_ferr) begin
            st   <= P_IDLE;
            busy <= 1'b0;
          end else if (rx_valid) begin
            wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
            bcnt      <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              st        <= P_BUS;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
              wbm_we_o  <= 1'b1;
`ifdef UART_WB_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end
          end
        P_BUS:
          if (wbm_ack_i) begin
            st        <= P_RESP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            resp      <= is_wr ? {8'hA5, 24'h0} : wbm_dat_i;
            resp_left <= is_wr ? 3'd1 : 3'd4;
          end
`ifdef UART_WB_TIMEOUT_EN
          else if (to_cnt == TIMEOUT - 16'd1) begin
            st        <= P_RESP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            resp      <= {8'hEE, 24'h0};
            resp_left <= 3'd1;
          end else to_cnt <= to_cnt + 16'd1;
`endif
        P_RESP:
          if (tx_load) begin
            resp      <= {resp[23:0], 8'h00};
            resp_left <= resp_left - 3'd1;
          end else if (resp_left == 3'd0 && tx_end) begin
            st   <= P_IDLE;
            busy <= 1'b0;
          end
        default: st <= P_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: randomized bench with a byte-level host/slave model and a per-cycle bus checker.
module tb_uart_wb_master;
  localparam int DI = 8;
  localparam int TO = 20;
  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i = 1'b0;
  logic        ser_rx = 1'b1, ser_tx, busy;
  int tests = 0, fails = 0;
  logic [31:0] exp_adr = '0, exp_dat = '0, rd_val = '0;
  logic        exp_we = 1'b0, ack_en = 1'b0, prev_cyc = 1'b0;
  int ack_delay = 0, wait_cnt = 0, cyc_rises = 0, cur_len = 0, last_len = 0, cycle_n = 0;
  logic [8:0] rxq[$];
  int tq[$];
  logic [8:0] mon_f;
  int mon_t0;

  uart_wb_master #(.CLK_DIV(16'd8), .TIMEOUT(16'd20)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .ser_rx(ser_rx), .ser_tx(ser_tx), .busy(busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cycle_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // bus checker and Wishbone slave model, sampled on the falling edge
  always @(negedge wb_clk_i) begin
    if (wbm_cyc_o) begin
      check("stb", {31'b0, wbm_stb_o}, 32'd1);
      check("sel", {28'b0, wbm_sel_o}, 32'hF);
      check("adr", wbm_adr_o, exp_adr);
      check("we", {31'b0, wbm_we_o}, {31'b0, exp_we});
      check("busy_bus", {31'b0, busy}, 32'd1);
      if (exp_we) check("wdat", wbm_dat_o, exp_dat);
      if (!prev_cyc) cyc_rises++;
      cur_len++;
    end else if (prev_cyc) begin
      check("stb_drop", {31'b0, wbm_stb_o}, 32'd0);
      last_len = cur_len;
      cur_len = 0;
    end
    prev_cyc = wbm_cyc_o;
    if (wbm_ack_i) begin
      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom;
    end else if (wbm_cyc_o && wbm_stb_o && ack_en) begin
      if (wait_cnt >= ack_delay) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rd_val;
      end else wait_cnt++;
    end else wbm_dat_i = $urandom;
    if (!wbm_cyc_o) wait_cnt = 0;
  end

  // serial monitor: decodes ser_tx frames into {stop, data} with start times
  initial forever begin
    @(negedge wb_clk_i);
    if (ser_tx === 1'b0 && !wb_rst_i) begin
      mon_t0 = cycle_n;
      repeat (DI / 2) @(negedge wb_clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (DI) @(negedge wb_clk_i);
        mon_f[i] = ser_tx;
      end
      repeat (DI) @(negedge wb_clk_i);
      mon_f[8] = ser_tx;
      rxq.push_back(mon_f);
      tq.push_back(mon_t0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    @(negedge wb_clk_i);
    ser_rx = 1'b0;
    repeat (DI) @(negedge wb_clk_i);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (DI) @(negedge wb_clk_i);
    end
    ser_rx = stop_v;
    repeat (DI) @(negedge wb_clk_i);
    ser_rx = 1'b1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(wr ? 8'h01 : 8'h02, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8], 1'b1);
    if (wr) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8], 1'b1);
  endtask

  task automatic set_exp(input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [31:0] rval, input int delay, input logic ack_on);
    exp_we = wr; exp_adr = adr; exp_dat = dat; rd_val = rval;
    ack_delay = delay; ack_en = ack_on; cyc_rises = 0;
    rxq.delete(); tq.delete();
  endtask

  function automatic logic [31:0] resp_word();
    logic [31:0] w = '0;
    foreach (rxq[i]) w = {w[23:0], rxq[i][7:0]};
    return w;
  endfunction

  // full transaction against the byte-level model of the expected response
  task automatic run_cmd(input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [31:0] rval, input int delay, input logic ack_on, input logic to);
    logic [7:0] exp_q[$];
    set_exp(wr, adr, dat, rval, delay, ack_on);
    if (to) exp_q.push_back(8'hEE);
    else if (wr) exp_q.push_back(8'hA5);
    else for (int i = 3; i >= 0; i--) exp_q.push_back(rval[i*8 +: 8]);
    send_cmd(wr, adr, dat);
    for (int k = 0; k < 3000 && rxq.size() < exp_q.size(); k++) @(negedge wb_clk_i);
    check("resp_count", rxq.size(), exp_q.size());
    for (int i = 0; i < rxq.size() && i < exp_q.size(); i++) begin
      check("resp_byte", {24'b0, rxq[i][7:0]}, {24'b0, exp_q[i]});
      check("resp_stop", {31'b0, rxq[i][8]}, 32'd1);
      if (i > 0) check("b2b_gap", tq[i] - tq[i-1], 10 * DI);
    end
    check("busy_tail", {31'b0, busy}, 32'd1);
    repeat (DI) @(negedge wb_clk_i);
    check("busy_end", {31'b0, busy}, 32'd0);
    check("bus_cycles", cyc_rises, 1);
    check("cyc_len", last_len, to ? TO : delay + 1);
  endtask

  initial begin
    repeat (5) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'b0, wbm_we_o}, 32'd0);
    check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_tx", {31'b0, ser_tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);

    run_cmd(1'b1, 32'h30000004, 32'hDEADBEEF, 32'h0, 3, 1'b1, 1'b0);
    check("t1_resp", resp_word(), 32'h000000A5);
    check("t1_len", last_len, 4);
    check("t1_adr_hold", wbm_adr_o, 32'h30000004);

    run_cmd(1'b0, 32'h30000008, 32'h0, 32'h12345678, 1, 1'b1, 1'b0);
    check("t2_resp", resp_word(), 32'h12345678);

    send_byte(8'h7F, 1'b1);
    @(negedge wb_clk_i); ser_rx = 1'b0;
    repeat (DI) @(negedge wb_clk_i); ser_rx = 1'b1;
    repeat (12 * DI) @(negedge wb_clk_i);
    ser_rx = 1'b0;
    repeat (2) @(negedge wb_clk_i); ser_rx = 1'b1;
    repeat (2 * DI) @(negedge wb_clk_i);
    check("glitch_busy", {31'b0, busy}, 32'd0);
    run_cmd(1'b0, 32'h3000000C, 32'h0, 32'hCAFEF00D, 2, 1'b1, 1'b0);

    set_exp(1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4 * DI) @(negedge wb_clk_i);
    check("ferr_busy", {31'b0, busy}, 32'd0);
    check("ferr_nobus", cyc_rises, 0);
    run_cmd(1'b1, 32'h30000010, 32'h01020304, 32'h0, 0, 1'b1, 1'b0);

`ifdef UART_WB_TIMEOUT_EN
    run_cmd(1'b0, 32'h30000020, 32'h0, 32'h55AA55AA, 0, 1'b0, 1'b1);
    check("to_resp", resp_word(), 32'h000000EE);
    run_cmd(1'b0, 32'h30000024, 32'h0, 32'h0BADF00D, TO - 1, 1'b1, 1'b0);
    check("to_race", resp_word(), 32'h0BADF00D);
`endif

    set_exp(1'b0, 32'h30000040, 32'h0, 32'h0, 0, 1'b0);
    send_cmd(1'b0, 32'h30000040, 32'h0);
    for (int k = 0; k < 200 && !wbm_cyc_o; k++) @(negedge wb_clk_i);
    check("rstA_cyc_seen", {31'b0, wbm_cyc_o}, 32'd1);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rstA_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rstA_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rstA_tx", {31'b0, ser_tx}, 32'd1);
    check("rstA_busy", {31'b0, busy}, 32'd0);

    set_exp(1'b1, 32'h30000044, 32'h11223344, 32'h0, 0, 1'b1);
    send_cmd(1'b1, 32'h30000044, 32'h11223344);
    for (int k = 0; k < 200 && ser_tx; k++) @(negedge wb_clk_i);
    check("rstB_tx_seen", {31'b0, ser_tx}, 32'd0);
    repeat (3 * DI) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("rstB_tx", {31'b0, ser_tx}, 32'd1);
    check("rstB_busy", {31'b0, busy}, 32'd0);
    check("rstB_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    repeat (12 * DI) @(negedge wb_clk_i);
    run_cmd(1'b0, 32'h30000048, 32'h0, 32'h89ABCDEF, 0, 1'b1, 1'b0);

    for (int n = 0; n < 8; n++)
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 6), 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Debug/bring-up bridge: a host on a serial line issues 32-bit Wishbone reads and writes into the user-project bus.
- Wishbone initiator side of the bus; UART on the far side.
- Receives framed command bytes on ser_rx, runs a single Wishbone classic cycle, returns the response on ser_tx.
- Sits beside the UART peripherals on the same wb_clk_i domain; an arbiter ahead of the slaves muxes it with the CPU master.

Parameters:
- CLK_DIV, 16'd217: bit period in wb_clk_i cycles. Legal range 4..65535.
- TIMEOUT, 16'd1023: cycles to wait for wbm_ack_i before aborting. Used only with UART_WB_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  read data.
- ser_rx  in  1  serial in, idle high.
- ser_tx  out  1  serial out, idle high.
- busy  out  1  high from the first command byte accepted until the last response stop bit completes.

Behaviour:
- Reset values: wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, wbm_sel_o=0, ser_tx=1, busy=0. Parser in IDLE; RX and TX engines idle.
- Reset mid-operation: aborts any bus cycle; cyc/stb drop on the cycle after reset is sampled. A partially sent TX byte is truncated with ser_tx=1.
- Synchroniser: ser_rx passes through a 2-flop synchroniser.
- RX engine: 8N1, LSB first.
  - A falling edge while idle starts the count; start bit is re-checked at CLK_DIV/2 (integer division). If high, it is a glitch and RX returns to idle.
  - Data bits are sampled every CLK_DIV cycles thereafter. Stop bit is sampled one CLK_DIV later.
  - Stop bit 0 = framing error: byte discarded, parser forced to IDLE.
  - A valid byte produces a 1-cycle rx_valid pulse.
- TX engine: 8N1, LSB first; each bit held exactly CLK_DIV cycles. Accepts a byte only when idle.
- Parser FSM: IDLE -> ADDR -> (WDATA) -> BUS -> RESP -> IDLE.
  - IDLE: byte 0x01 = write, 0x02 = read; goes to ADDR with byte count 0. Any other byte is dropped and the FSM stays in IDLE.
  - ADDR: 4 bytes, MSB first, shifted into wbm_adr_o. After the 4th byte, a write goes to WDATA and a read goes to BUS.
  - WDATA: 4 bytes, MSB first, into wbm_dat_o; then BUS.
  - BUS: cyc/stb/sel asserted on the cycle after the final byte's rx_valid; wbm_we_o=1 for writes. Held until wbm_ack_i is sampled high; cyc/stb deassert on the next cycle. Read data is latched on the ack cycle.
  - RESP: a write returns one byte, 0xA5. A read returns 4 bytes, MSB first, back-to-back with no idle bit between frames. Then IDLE; busy clears when the final stop bit ends.
- Bytes received in BUS or RESP are discarded and do not affect state. The host must wait for the response.
- An ack while the FSM is not in BUS is ignored.
- Address and data registers hold their last values after a transaction completes.

Optional Feature:
- UART_WB_TIMEOUT_EN defined:
  - A 16-bit counter is cleared on entering BUS and increments each cycle in BUS.
  - When it reaches TIMEOUT without an ack, cyc/stb drop on the next cycle and the response is the single byte 0xEE. This applies to both reads and writes.
  - An ack on the same cycle the counter reaches TIMEOUT wins, giving a normal response.
- Undefined: no counter; BUS waits indefinitely for wbm_ack_i.

Test Plan:
- CLK_DIV=8. Send 01 30 00 00 04 DE AD BE EF; slave acks after 3 cycles. Expect one cycle with adr=0x30000004, dat=0xDEADBEEF, we=1, sel=F; then TX byte A5; busy low afterward.
- Send 02 30 00 00 08; slave returns 0x12345678 with ack. Expect TX bytes 12 34 56 78 back-to-back, we=0 throughout.
- Send 7F, then a 1-bit-period low glitch, then 02 + address. Expect 7F and the glitch ignored, and the read performed normally.
- Stop bit forced low on the 2nd address byte. Expect the parser back in IDLE, no bus cycle. A following full write command succeeds.
- UART_WB_TIMEOUT_EN, TIMEOUT=20, slave never acks on a read. Expect cyc high for 20 cycles then low, TX 0xEE. Repeat with ack on cycle 20: expect the normal 4-byte response.
- Assert wb_rst_i for 1 cycle while in BUS and while mid-TX. Expect cyc/stb=0 and ser_tx=1 the next cycle, busy=0; a subsequent command succeeds.
